// File: rtl/intercal_alu_pkg.sv
// intercal_alu_pkg: shared widths, opcodes, FSM states and requester id type
package intercal_alu_pkg;
    localparam int DATA_W = 32;
    localparam int OP_W = 4;
    localparam logic [OP_W-1:0] OP_MINGLE = 4'd0;
    localparam logic [OP_W-1:0] OP_SELECT = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR = 4'd4;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef logic id_t;
endpackage

// File: rtl/intercal_alu.sv
// intercal_alu: INTERCAL mingle/select and unary rotate-logic operators; other ops pass a through
module intercal_alu #(
    parameter int DATA_W = intercal_alu_pkg::DATA_W,
    parameter int OP_W = intercal_alu_pkg::OP_W
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] f
);
    import intercal_alu_pkg::*;

    logic [DATA_W-1:0] mingle, sel, rot;

    assign rot = {a[0], a[DATA_W-1:1]};

    // mingle puts a in the odd bits; select packs a's bits under b's ones, MSB first
    always_comb begin
        mingle = '0;
        sel = '0;
        for (int i = 0; i < DATA_W / 2; i++) begin
            mingle[2*i+1] = a[i];
            mingle[2*i] = b[i];
        end
        for (int i = DATA_W - 1; i >= 0; i--)
            if (b[i]) sel = {sel[DATA_W-2:0], a[i]};
    end

    always_comb
        f = op == OP_MINGLE ? mingle :
            op == OP_SELECT ? sel :
            op == OP_AND    ? (a & rot) :
            op == OP_OR     ? (a | rot) :
            op == OP_XOR    ? (a ^ rot) : a;
endmodule

// File: rtl/intercal_alu_arbiter.sv
// intercal_alu_arbiter: two requesters share one intercal_alu through an IDLE/EXEC/RESP FSM
module intercal_alu_arbiter #(
    parameter int DATA_W = intercal_alu_pkg::DATA_W,
    parameter int OP_W = intercal_alu_pkg::OP_W,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_f,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);
    import intercal_alu_pkg::*;

    state_t state, state_nx;
    id_t last_grant, gnt, id_q;
    logic [OP_W-1:0] op_q;
    logic [DATA_W-1:0] a_q, b_q, f;
    logic accept;

    // on a tie the requester that did not win last time goes next
    assign gnt = req_valid == 2'b11 ? ~last_grant : req_valid[1];
    assign req_ready = (state == IDLE && rst_n) ? (req_valid & (gnt ? 2'b10 : 2'b01)) : 2'b00;
    assign accept = |req_ready;
    assign rsp_valid = state == RESP;
    assign busy = state != IDLE;

    always_comb
        state_nx = state == IDLE ? (accept ? EXEC : IDLE) :
                   state == EXEC ? RESP :
                   state == RESP ? (rsp_ready ? IDLE : RESP) : IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            last_grant <= 1'b1;
            id_q <= 1'b0;
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            rsp_id <= 1'b0;
            rsp_f <= '0;
            op_count <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                last_grant <= gnt;
                id_q <= gnt;
                op_q <= gnt ? req1_op : req0_op;
                a_q <= gnt ? req1_a : req0_a;
                b_q <= gnt ? req1_b : req0_b;
            end
            if (state == EXEC) begin
                rsp_f <= f;
                rsp_id <= id_q;
            end
            if (rsp_valid && rsp_ready) op_count <= op_count + CNT_W'(1);
        end
    end

    intercal_alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
        .op(op_q),
        .a(a_q),
        .b(b_q),
        .f(f)
    );
endmodule

// File: tb/tb_intercal_alu_arbiter.sv
// tb_intercal_alu_arbiter: directed steps with hand-computed results; narrow counter makes wrap reachable
module tb_intercal_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [3:0] req0_op = 4'd0, req1_op = 4'd0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic rsp_valid, rsp_ready = 1'b0, rsp_id, busy;
    logic [31:0] rsp_f;
    logic [7:0] op_count;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    intercal_alu_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(req0_op), .req1_op(req1_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_a(req1_a), .req1_b(req1_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_f(rsp_f), .busy(busy), .op_count(op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // reset, with both requesters asserting to show req_ready is held off
        req_valid = 2'b11;
        step(2);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_op_count", 32'(op_count), 32'h0);
        chk("rst_rsp_f", rsp_f, 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        step();
        // single requester 0, mingle of 0xFFFF and 0x5678
        req_valid = 2'b01;
        req0_op = 4'd0; req0_a = 32'h0000FFFF; req0_b = 32'h12345678;
        #1 chk("r0_req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        chk("r0_exec_busy", 32'(busy), 32'h1);
        chk("r0_exec_ready", 32'(req_ready), 32'h0);
        chk("r0_exec_valid", 32'(rsp_valid), 32'h0);
        step();
        chk("r0_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("r0_rsp_id", 32'(rsp_id), 32'h0);
        chk("r0_rsp_f", rsp_f, 32'hBBBEBFEA);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("r0_op_count", 32'(op_count), 32'h1);
        chk("r0_idle_busy", 32'(busy), 32'h0);
        // requester 1 select; response held for 10 cycles while req1 toggles valid
        req_valid = 2'b10;
        req0_op = 4'd2; req0_a = 32'hCAFEF00D;
        req1_op = 4'd1; req1_a = 32'h12345678; req1_b = 32'hF0F0F0F0;
        #1 chk("r1_req_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 2'b00;
        step();
        chk("hold_rsp_f0", rsp_f, 32'h00001357);
        chk("hold_rsp_id0", 32'(rsp_id), 32'h1);
        for (int i = 0; i < 10; i++) begin
            req_valid = i[0] ? 2'b10 : 2'b00;
            #1 chk("hold_req_ready", 32'(req_ready), 32'h0);
            step();
            chk("hold_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("hold_rsp_f", rsp_f, 32'h00001357);
            chk("hold_rsp_id", 32'(rsp_id), 32'h1);
            chk("hold_busy", 32'(busy), 32'h1);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("hold_op_count", 32'(op_count), 32'h2);
        step(2);
        chk("drop_no_rsp", 32'(rsp_valid), 32'h0);
        chk("drop_no_busy", 32'(busy), 32'h0);
        chk("drop_no_ready", 32'(req_ready), 32'h0);
        // both requesters continuously valid: grants alternate 0,1,0,1
        req0_op = 4'd4; req0_a = 32'h00000001; req0_b = 32'h0;
        req1_op = 4'd3; req1_a = 32'h00000003; req1_b = 32'h0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_req_ready", 32'(req_ready), k[0] ? 32'h2 : 32'h1);
            step(2);
            chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("rr_rsp_id", 32'(rsp_id), 32'(k[0]));
            chk("rr_rsp_f", rsp_f, k[0] ? 32'h80000003 : 32'h80000001);
            step();
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        chk("rr_op_count", 32'(op_count), 32'h6);
        // reset while in EXEC discards the operation and restores the tie order
        req_valid = 2'b01;
        req0_op = 4'd7; req0_a = 32'hDEADBEEF;
        step();
        req_valid = 2'b00;
        rst_n = 1'b0;
        step();
        chk("rx_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rx_busy", 32'(busy), 32'h0);
        chk("rx_op_count", 32'(op_count), 32'h0);
        rst_n = 1'b1;
        req_valid = 2'b11;
        #1 chk("rx_tie_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        step();
        chk("rx_rsp_f", rsp_f, 32'hDEADBEEF);
        chk("rx_rsp_id", 32'(rsp_id), 32'h0);
        rsp_ready = 1'b1;
        step();
        chk("rx_op_count1", 32'(op_count), 32'h1);
        // run the 8-bit counter up to all-ones, then one more handshake wraps it
        req_valid = 2'b01;
        req0_op = 4'd2; req0_a = 32'hFFFFFFFF;
        for (int n = 0; n < 1000 && op_count != 8'hFF; n++) step();
        chk("wrap_top", 32'(op_count), 32'hFF);
        chk("wrap_rsp_f", rsp_f, 32'hFFFFFFFF);
        step(3);
        req_valid = 2'b00;
        chk("wrap_zero", 32'(op_count), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
